pixel_pack_writer: RTL and testbench
====================================

PIXEL_PACK_WRITER -- requirements
Module: pixel_pack_writer

Interface
REQ-001 Parameter COLS, default 512, pixels per image row; SHALL be a multiple of 4.
REQ-002 Parameter ROWS, default 480, rows per frame.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins accepting a frame.
REQ-006 res_data  input  24  signed two's-complement convolution result.
REQ-007 res_valid  input  1  res_data is valid this cycle.
REQ-008 res_ready  output  1  block accepts res_data this cycle.
REQ-009 mem_addr  output  16  word address {row[8:0], col[8:2]}.
REQ-010 mem_data  output  32  four packed 8-bit pixels.
REQ-011 mem_we  output  1  one-cycle write strobe to frame memory.
REQ-012 busy  output  1  high from the accepted start until frame_done.
REQ-013 frame_done  output  1  one-cycle pulse after the last word of the frame is written.

Function
REQ-014 States SHALL be IDLE, ACCUM, WRITE and DONE.
REQ-015 IDLE: start=1 -> ACCUM, with row=0, col=0 and the pack register cleared.
REQ-016 ACCUM: res_ready=1; a pixel is accepted on res_valid&&res_ready.
REQ-017 Each accepted pixel SHALL be stored in byte lane col[1:0], bits [8*col[1:0]+7 : 8*col[1:0]] of the pack register; col then increments.
REQ-018 Pixel conversion without the macro: pixel = res_data[7:0].
REQ-019 When the accepted pixel has col[1:0]==3 -> WRITE on the next cycle.
REQ-020 WRITE: for exactly one cycle, mem_we=1, res_ready=0, mem_data=pack register, mem_addr={row, word col}.
REQ-021 After WRITE, when col has wrapped from COLS-1 to 0, row SHALL increment.
REQ-022 After WRITE, if the written word was the last word (row ROWS-1, col COLS-4..COLS-1) -> DONE; otherwise -> ACCUM.
REQ-023 DONE: frame_done=1 for one cycle, then -> IDLE.
REQ-024 busy SHALL be high in ACCUM, WRITE and DONE; frame_done and busy are both high in the DONE cycle.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 res_valid SHALL be ignored in IDLE, WRITE and DONE; no pixel is consumed there.
REQ-027 mem_addr and mem_data SHALL hold their last written value when mem_we=0.
REQ-028 Sustained throughput SHALL be 4 pixels per 5 cycles; latency from acceptance of the 4th pixel to mem_we SHALL be 1 cycle.
REQ-029 Gaps in res_valid SHALL NOT corrupt the pack register or the counters.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge, in any state including mid-frame.
REQ-031 On reset, all outputs SHALL be 0: res_ready, mem_we, busy, frame_done, mem_addr, mem_data.
REQ-032 On reset, row, col and the pack register SHALL be 0.
REQ-033 A write in progress at reset SHALL be dropped; no partial word is written.
REQ-034 reset SHALL take priority over start when both are asserted.

Configuration
REQ-035 Macro PIXEL_SAT_CLAMP_EN: when defined, pixel = 0 if res_data<0, 255 if res_data>255, otherwise res_data[7:0].
REQ-036 When PIXEL_SAT_CLAMP_EN is undefined, truncation per REQ-018 SHALL apply and no clamp logic is present.
REQ-037 The macro SHALL NOT change timing, states or the interface.

Verification
REQ-038 Frame start and first word: start, then pixels 0x11,0x22,0x33,0x44 back-to-back -> one cycle later mem_we=1, mem_addr=0x0000, mem_data=0x44332211.
REQ-039 Row wrap: after 512 pixels, pixel 513 is written in the next row's first word -> mem_addr=0x0080.
REQ-040 Full frame, COLS=8, ROWS=2: 16 pixels in -> 4 writes to addresses 0x0000, 0x0001, 0x0080, 0x0081, then frame_done one cycle after the last mem_we, then busy=0.
REQ-041 Clamping: res_data = -5, 300, 128, 0x000101 -> with PIXEL_SAT_CLAMP_EN mem_data=0xFF80FF00; without it mem_data=0x0180 2CFB, i.e. 0x01802CFB.
REQ-042 Reset mid-frame after 2 pixels: no mem_we; all outputs 0; a new start then writes its first word to 0x0000.
REQ-043 Back-pressure: res_valid held high -> res_ready=0 exactly in each WRITE cycle, and no pixel is lost or duplicated.

Source files
------------

// File: rtl/pixel_pack_writer.sv
// Packs signed convolution results into 32-bit words of four 8-bit pixels and writes them to frame memory.
// Optional macro PIXEL_SAT_CLAMP_EN: saturate each result to 0..255 instead of truncating to its low byte.
module pixel_pack_writer #(
    parameter int COLS = 512,
    parameter int ROWS = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] COL_LAST = 9'(COLS - 1);
    localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);

    state_t      state_r;
    logic [8:0]  row_r;
    logic [8:0]  col_r;
    logic [31:0] pack_r;
    logic        wrap_r;

    logic [7:0]  pixel_s;
    logic [31:0] pack_next_s;
    logic [8:0]  col_next_s;
    logic        accept_s;

    function automatic logic [7:0] to_pixel(input logic [23:0] d);
`ifdef PIXEL_SAT_CLAMP_EN
        if (d[23]) begin
            return 8'h00;
        end else if (d[22:8] != 15'd0) begin
            return 8'hFF;
        end else begin
            return d[7:0];
        end
`else
        return d[7:0];
`endif
    endfunction

    // Pixel conversion, lane insertion and column advance for the pixel offered this cycle
    always_comb begin
        pixel_s     = to_pixel(res_data);
        pack_next_s = pack_r;
        accept_s    = (state_r == ACCUM) && res_valid && res_ready;
        col_next_s  = (col_r == COL_LAST) ? 9'd0 : (col_r + 9'd1);
        case (col_r[1:0])
            2'd0:    pack_next_s[7:0]   = pixel_s;
            2'd1:    pack_next_s[15:8]  = pixel_s;
            2'd2:    pack_next_s[23:16] = pixel_s;
            2'd3:    pack_next_s[31:24] = pixel_s;
            default: pack_next_s        = pack_r;
        endcase
    end

    // Frame sequencer with registered handshake and memory outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            row_r      <= 9'd0;
            col_r      <= 9'd0;
            pack_r     <= 32'd0;
            wrap_r     <= 1'b0;
            res_ready  <= 1'b0;
            mem_addr   <= 16'd0;
            mem_data   <= 32'd0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_we     <= 1'b0;
                    frame_done <= 1'b0;
                    if (start) begin
                        state_r   <= ACCUM;
                        row_r     <= 9'd0;
                        col_r     <= 9'd0;
                        pack_r    <= 32'd0;
                        wrap_r    <= 1'b0;
                        res_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        res_ready <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        pack_r <= pack_next_s;
                        col_r  <= col_next_s;
                        wrap_r <= (col_r == COL_LAST);
                        // The fourth lane completes a word: emit it straight from the merged value
                        if (col_r[1:0] == 2'd3) begin
                            state_r   <= WRITE;
                            res_ready <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= {row_r, col_r[8:2]};
                            mem_data  <= pack_next_s;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (wrap_r && (row_r == ROW_LAST)) begin
                        state_r    <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state_r   <= ACCUM;
                        res_ready <= 1'b1;
                        if (wrap_r) begin
                            row_r <= row_r + 9'd1;
                        end else begin
                            row_r <= row_r;
                        end
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    res_ready  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    res_ready  <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Self-checking bench for pixel_pack_writer on a small 8x2 frame with a queue-based reference model.
module tb_pixel_pack_writer;

    localparam int COLS = 8;
    localparam int ROWS = 2;
    localparam int WPR  = COLS / 4;
    localparam int NPIX = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] res_data = 24'd0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic        frame_done;

    pixel_pack_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset), .start(start), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_in_write = 0;
    int hold_err = 0;
    logic [15:0] prev_addr = 16'd0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_reset = 1'b1;
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_q[$];

    // Write/done monitor plus hold-value and back-pressure watch
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
            wc_q.push_back(cyc);
            if (res_ready) ready_in_write <= ready_in_write + 1;
        end
        if (frame_done) done_q.push_back(cyc);
        if (!mem_we && !prev_reset && (mem_addr !== prev_addr || mem_data !== prev_data))
            hold_err <= hold_err + 1;
        prev_addr  <= mem_addr;
        prev_data  <= mem_data;
        prev_reset <= reset;
    end

    function automatic logic [7:0] conv(input logic [23:0] d);
`ifdef PIXEL_SAT_CLAMP_EN
        if ($signed(d) < 0) return 8'd0;
        else if ($signed(d) > 255) return 8'd255;
        else return d[7:0];
`else
        return d[7:0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] d, input int gap_max);
        int  n;
        logic r;
        n = int'($urandom_range(gap_max, 0));
        if (n > 0) begin
            res_valid = 1'b0;
            repeat (n) tick();
        end
        res_valid = 1'b1;
        res_data  = d;
        for (int k = 0; k < 20; k++) begin
            r = res_ready;
            tick();
            if (r) return;
        end
        checks++;
        errors++;
        $error("FAIL send_timeout observed no handshake expected res_ready within 20 cycles");
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            tick();
        end
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    task automatic check_frame(input logic [7:0] pix[$], input int base, input string tag);
        logic [31:0] ed;
        logic [15:0] ea;
        chk({tag, "_nwords"}, 32'(wa_q.size() - base), 32'(NPIX / 4));
        for (int w = 0; w < NPIX / 4; w++) begin
            ed = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
            ea = 16'((w / WPR) * 128 + (w % WPR));
            chk($sformatf("%s_addr%0d", tag, w), 32'(wa_q[base+w]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, w), wd_q[base+w], ed);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(res_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, mem_data, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed no finish expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  pix[$];
        logic [23:0] d;
        logic [23:0] clamp_in[4];
        int          base;

        // Reset wins over a simultaneous start
        reset = 1'b1; start = 1'b1; res_valid = 1'b1; res_data = 24'h123456;
        tick(); tick();
        chk_zero("reset");

        // res_valid is ignored in IDLE
        reset = 1'b0; start = 1'b0;
        repeat (3) tick();
        chk("idle_ready", 32'(res_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_write", 32'(wa_q.size()), 32'd0);

        // Frame 1: back-to-back pixels with res_valid held high
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(res_ready), 32'd1);
        base = wa_q.size();
        pix.delete();
        for (int i = 0; i < 4; i++) begin
            d = 24'(8'h11 * (i + 1));
            send(d, 0);
            pix.push_back(conv(d));
        end
        chk("first_we", 32'(mem_we), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'h0000);
        chk("first_data", mem_data, 32'h44332211);
        chk("first_ready_low", 32'(res_ready), 32'd0);
        for (int i = 4; i < NPIX; i++) begin
            d = 24'($urandom);
            start = (i == 9);
            send(d, 0);
            pix.push_back(conv(d));
        end
        start = 1'b0;
        res_valid = 1'b0;
        wait_idle("f1");
        check_frame(pix, base, "f1");
        chk("f1_done_count", 32'(done_q.size()), 32'd1);
        chk("f1_done_lat", 32'(done_q[0] - wc_q[wc_q.size()-1]), 32'd1);
        chk("f1_rate", 32'(wc_q[base+3] - wc_q[base]), 32'd15);
        chk("f1_ready_in_write", 32'(ready_in_write), 32'd0);

        // Frame 2: conversion of out-of-range values, then reset after two more pixels
        start = 1'b1; tick(); start = 1'b0;
        base = wa_q.size();
        clamp_in[0] = 24'hFFFFFB;
        clamp_in[1] = 24'd300;
        clamp_in[2] = 24'd128;
        clamp_in[3] = 24'h000101;
        for (int i = 0; i < 4; i++) send(clamp_in[i], 0);
        chk("clamp_we", 32'(mem_we), 32'd1);
        chk("clamp_data", mem_data,
            {conv(clamp_in[3]), conv(clamp_in[2]), conv(clamp_in[1]), conv(clamp_in[0])});
        send(24'h0000AA, 0);
        send(24'h0000BB, 0);
        res_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk_zero("mid_reset");
        chk("mid_reset_writes", 32'(wa_q.size() - base), 32'd1);

        // Frame 3: random gaps in res_valid, stray start while busy
        start = 1'b1; tick(); start = 1'b0;
        base = wa_q.size();
        pix.delete();
        for (int i = 0; i < NPIX; i++) begin
            d = 24'($urandom);
            start = (i == 5);
            send(d, 3);
            pix.push_back(conv(d));
        end
        start = 1'b0;
        res_valid = 1'b0;
        wait_idle("f3");
        check_frame(pix, base, "f3");
        chk("f3_done_count", 32'(done_q.size()), 32'd2);
        chk("f3_done_lat", 32'(done_q[1] - wc_q[wc_q.size()-1]), 32'd1);
        chk("hold_values", 32'(hold_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
